// File: rtl/pattern_search_pkg.sv
// Shared types for the pattern search engine.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// state_t carries fixed 4-bit codes; they are exported on actual_state, so
// any debug tooling can decode them directly.
package pattern_search_pkg;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    INIT  = 4'd1,
    CHECK = 4'd2,
    FETCH = 4'd3,
    CMP   = 4'd4,
    HIT   = 4'd5,
    DONE  = 4'd6
  } state_t;

  localparam logic MODE_ALL   = 1'b0;  // report every (overlapping) match
  localparam logic MODE_FIRST = 1'b1;  // stop at the first match

endpackage

// File: rtl/pos_log_fifo.sv
// Small synchronous FIFO holding the text positions of matches.
// Latency: push visible on pop_vld/pop_dat the cycle after the push edge.
// Backpressure: none; a push into a full FIFO is dropped and sets sticky ovf.
//
// Only built when SEARCH_POS_LOG_EN is defined; without it the search engine
// has no position log and this module does not exist.
//
// Ports:
//   clk, rst      clock, async active-low reset
//   flush         clear contents and ovf (synchronous, wins over push/pop)
//   push/push_dat write one entry
//   pop           discard head entry; ignored when empty
//   pop_vld       FIFO holds at least one entry
//   pop_dat       head entry
//   ovf           a push was dropped since the last flush/reset
`ifdef SEARCH_POS_LOG_EN
module pos_log_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 8,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic         pop_vld,
  output logic [W-1:0] pop_dat,
  output logic         ovf
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic          full, do_pop, do_push;

  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full    = (cnt == CW'(DEPTH));
  assign pop_vld = (cnt != '0);
  assign pop_dat = mem[rd_ptr];
  assign do_pop  = pop && pop_vld;
  // A simultaneous pop frees the slot, so the push still lands when full.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
      if (push && !do_push) ovf <= 1'b1;
    end
  end

endmodule
`endif

// File: rtl/pattern_search_engine.sv
// Naive sliding-window text/pattern search over two external 1-cycle RAMs.
// Latency: INIT one cycle after start, then 2 cycles per character compare,
//          1 cycle per window check and 1 per hit; done pulses for one cycle.
// Backpressure: none; start is only honoured in IDLE, ignored while busy.
//
// Optional feature: define SEARCH_POS_LOG_EN to add a match-position FIFO
// (ports pos_pop, pos_valid, pos_data, pos_overflow; parameter POS_DEPTH).
//
// Ports:
//   clk, rst          clock, async active-low reset
//   start, mode       launch; 0 = all overlapping matches, 1 = stop at first
//   text_len, pat_len lengths, captured in INIT (text_len clamps to TXT_DEPTH)
//   txt_addr/txt_data text RAM read port (data one cycle after address)
//   pat_addr/pat_data pattern RAM read port (data one cycle after address)
//   busy, done        search in progress / one-cycle completion pulse
//   found, match_count, first_pos  results, held until the next INIT
//   actual_state      current state code
module pattern_search_engine
  import pattern_search_pkg::*;
#(
  parameter  int CHAR_W    = 8,
  parameter  int TXT_DEPTH = 64,
  parameter  int PAT_DEPTH = 16,
  parameter  int CNT_W     = 8,
`ifdef SEARCH_POS_LOG_EN
  parameter  int POS_DEPTH = 4,
`endif
  localparam int TXT_AW    = $clog2(TXT_DEPTH),
  localparam int PAT_AW    = $clog2(PAT_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [TXT_AW:0]   text_len,
  input  logic [PAT_AW:0]   pat_len,
  output logic [TXT_AW-1:0] txt_addr,
  input  logic [CHAR_W-1:0] txt_data,
  output logic [PAT_AW-1:0] pat_addr,
  input  logic [CHAR_W-1:0] pat_data,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic [CNT_W-1:0]  match_count,
  output logic [TXT_AW-1:0] first_pos,
  output logic [3:0]        actual_state
`ifdef SEARCH_POS_LOG_EN
  ,
  input  logic              pos_pop,
  output logic              pos_valid,
  output logic [TXT_AW-1:0] pos_data,
  output logic              pos_overflow
`endif
);

  localparam int BW = TXT_AW + 1;  // base / text length width
  localparam int KW = PAT_AW + 1;  // offset / pattern length width
  localparam int SW = TXT_AW + 2;  // window end, wide enough never to wrap

  state_t        state, state_nxt;
  logic [BW-1:0] base, tl_q, tl_clamped;
  logic [KW-1:0] koff, pl_q;
  logic          mode_q;
  logic [SW-1:0] window_end;
  logic          window_ok, char_eq, last_char, busy_nxt;

  assign tl_clamped = (text_len > BW'(TXT_DEPTH)) ? BW'(TXT_DEPTH) : text_len;
  assign window_end = SW'(base) + SW'(pl_q);
  assign window_ok  = (pl_q != '0) && (window_end <= SW'(tl_q));
  assign char_eq    = (txt_data == pat_data);
  assign last_char  = ((koff + KW'(1)) == pl_q);

  // Addresses are only driven in FETCH; elsewhere base may already point one
  // past the last legal window, so they are parked at 0.
  assign txt_addr = (state == FETCH) ? (TXT_AW'(base) + TXT_AW'(koff)) : '0;
  assign pat_addr = (state == FETCH) ? PAT_AW'(koff) : '0;

  assign actual_state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = INIT;
      INIT:    state_nxt = CHECK;
      CHECK:   state_nxt = window_ok ? FETCH : DONE;
      FETCH:   state_nxt = CMP;
      CMP: begin
        if (!char_eq)      state_nxt = CHECK;
        else if (last_char) state_nxt = HIT;
        else               state_nxt = FETCH;
      end
      HIT:     state_nxt = (mode_q == MODE_FIRST) ? DONE : CHECK;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy_nxt = (state_nxt inside {INIT, CHECK, FETCH, CMP, HIT});

  // busy/done are registered from the next state so they line up exactly
  // with the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      found       <= 1'b0;
      match_count <= '0;
      first_pos   <= '0;
      base        <= '0;
      koff        <= '0;
      tl_q        <= '0;
      pl_q        <= '0;
      mode_q      <= 1'b0;
    end else begin
      busy <= busy_nxt;
      done <= (state_nxt == DONE);
      case (state)
        INIT: begin
          tl_q        <= tl_clamped;
          pl_q        <= pat_len;
          mode_q      <= mode;
          base        <= '0;
          koff        <= '0;
          found       <= 1'b0;
          match_count <= '0;
          first_pos   <= '0;
        end
        CMP: begin
          if (!char_eq) begin
            base <= base + BW'(1);
            koff <= '0;
          end else if (!last_char) begin
            koff <= koff + KW'(1);
          end
        end
        HIT: begin
          if (match_count != {CNT_W{1'b1}}) match_count <= match_count + CNT_W'(1);
          if (!found) first_pos <= TXT_AW'(base);
          found <= 1'b1;
          if (mode_q != MODE_FIRST) begin
            base <= base + BW'(1);
            koff <= '0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SEARCH_POS_LOG_EN
  pos_log_fifo #(
    .DEPTH (POS_DEPTH),
    .W     (TXT_AW)
  ) u_pos_log (
    .clk      (clk),
    .rst      (rst),
    .flush    (state == INIT),
    .push     (state == HIT),
    .push_dat (TXT_AW'(base)),
    .pop      (pos_pop),
    .pop_vld  (pos_valid),
    .pop_dat  (pos_data),
    .ovf      (pos_overflow)
  );
`endif

endmodule

// File: tb/tb_pattern_search_engine.sv
// Bench for pattern_search_engine: two instances (CNT_W=8 and CNT_W=2) run the
// same directed searches against one shared text/pattern memory image; a
// behavioural model predicts completion cycle and results for each search.
module tb_pattern_search_engine;
  import pattern_search_pkg::*;

  localparam int CHAR_W = 8, TXT_DEPTH = 64, PAT_DEPTH = 16;
  localparam int TXT_AW = 6, PAT_AW = 4;

  logic clk = 1'b0, rst = 1'b0, start = 1'b0, mode = 1'b0;
  logic [TXT_AW:0] text_len = '0;
  logic [PAT_AW:0] pat_len = '0;
  logic [CHAR_W-1:0] tmem [TXT_DEPTH];
  logic [CHAR_W-1:0] pmem [PAT_DEPTH];

  logic [TXT_AW-1:0] d8_txt_addr, d2_txt_addr, d8_first_pos, d2_first_pos;
  logic [PAT_AW-1:0] d8_pat_addr, d2_pat_addr;
  logic [CHAR_W-1:0] d8_txt_data, d2_txt_data, d8_pat_data, d2_pat_data;
  logic d8_busy, d2_busy, d8_done, d2_done, d8_found, d2_found;
  logic [7:0] d8_match_count;
  logic [1:0] d2_match_count;
  logic [3:0] d8_actual_state, d2_actual_state;
`ifdef SEARCH_POS_LOG_EN
  logic d8_pos_pop = 1'b0, d2_pos_pop = 1'b0;
  logic d8_pos_valid, d2_pos_valid, d8_pos_overflow, d2_pos_overflow;
  logic [TXT_AW-1:0] d8_pos_data, d2_pos_data;
`endif

  pattern_search_engine #(
    .CHAR_W(CHAR_W), .TXT_DEPTH(TXT_DEPTH), .PAT_DEPTH(PAT_DEPTH), .CNT_W(8)
`ifdef SEARCH_POS_LOG_EN
    , .POS_DEPTH(1)
`endif
  ) d8 (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .text_len(text_len), .pat_len(pat_len),
    .txt_addr(d8_txt_addr), .txt_data(d8_txt_data),
    .pat_addr(d8_pat_addr), .pat_data(d8_pat_data),
    .busy(d8_busy), .done(d8_done), .found(d8_found),
    .match_count(d8_match_count), .first_pos(d8_first_pos),
    .actual_state(d8_actual_state)
`ifdef SEARCH_POS_LOG_EN
    , .pos_pop(d8_pos_pop), .pos_valid(d8_pos_valid),
    .pos_data(d8_pos_data), .pos_overflow(d8_pos_overflow)
`endif
  );

  pattern_search_engine #(
    .CHAR_W(CHAR_W), .TXT_DEPTH(TXT_DEPTH), .PAT_DEPTH(PAT_DEPTH), .CNT_W(2)
  ) d2 (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .text_len(text_len), .pat_len(pat_len),
    .txt_addr(d2_txt_addr), .txt_data(d2_txt_data),
    .pat_addr(d2_pat_addr), .pat_data(d2_pat_data),
    .busy(d2_busy), .done(d2_done), .found(d2_found),
    .match_count(d2_match_count), .first_pos(d2_first_pos),
    .actual_state(d2_actual_state)
`ifdef SEARCH_POS_LOG_EN
    , .pos_pop(d2_pos_pop), .pos_valid(d2_pos_valid),
    .pos_data(d2_pos_data), .pos_overflow(d2_pos_overflow)
`endif
  );

  always #5 clk = ~clk;

  // 1-cycle-latency RAMs
  always @(posedge clk) begin
    d8_txt_data <= tmem[d8_txt_addr];
    d8_pat_data <= pmem[d8_pat_addr];
    d2_txt_data <= tmem[d2_txt_addr];
    d2_pat_data <= pmem[d2_pat_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0, fails = 0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit exp_valid = 1'b0;
  int exp_s, exp_d, exp_n, exp_first, exp_tl, exp_pl;
  int exp_pos[$];
  int last_done = -1;

  // Scans the memory image window by window. Cost of a window: one check
  // cycle, two cycles per character examined, one extra cycle on a match.
  // An exhausted scan spends one more check cycle before DONE.
  task automatic model(input int tl, input int pl, input bit md);
    int dur = 0;
    bit stopped = 1'b0;
    exp_tl = (tl > TXT_DEPTH) ? TXT_DEPTH : tl;
    exp_pl = pl;
    exp_n = 0;
    exp_first = 0;
    exp_pos.delete();
    if (pl > 0) begin
      for (int b = 0; (b + pl <= exp_tl) && !stopped; b++) begin
        int c = 0;
        bit ok = 1'b1;
        for (int j = 0; j < pl; j++) begin
          c++;
          if (tmem[b + j] != pmem[j]) begin
            ok = 1'b0;
            break;
          end
        end
        dur += 1 + 2 * c + (ok ? 1 : 0);
        if (ok) begin
          if (exp_n == 0) exp_first = b;
          exp_n++;
          exp_pos.push_back(b);
          if (md) stopped = 1'b1;
        end
      end
    end
    exp_d = exp_s + 1 + dur + (stopped ? 0 : 1);
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (exp_valid && rst) begin
      chk("busy8", d8_busy, (cyc >= exp_s && cyc < exp_d) ? 1 : 0);
      chk("busy2", d2_busy, (cyc >= exp_s && cyc < exp_d) ? 1 : 0);
      chk("done8", d8_done, (cyc == exp_d) ? 1 : 0);
      chk("done2", d2_done, (cyc == exp_d) ? 1 : 0);
      if (d8_done) last_done = cyc;
      if (cyc == exp_s)     chk("state_init", d8_actual_state, int'(INIT));
      if (cyc == exp_s + 1) chk("state_check", d8_actual_state, int'(CHECK));
      if (cyc == exp_d)     chk("state_done", d8_actual_state, int'(DONE));
      if (cyc == exp_d + 1) chk("state_idle", d8_actual_state, int'(IDLE));
      chk("txt_addr_rng", (d8_txt_addr < exp_tl || d8_txt_addr == 0) ? 1 : 0, 1);
      chk("pat_addr_rng", (d8_pat_addr < exp_pl || d8_pat_addr == 0) ? 1 : 0, 1);
      if (cyc >= exp_d) begin
        chk("found8", d8_found, (exp_n > 0) ? 1 : 0);
        chk("found2", d2_found, (exp_n > 0) ? 1 : 0);
        chk("count8", d8_match_count, (exp_n > 255) ? 255 : exp_n);
        chk("count2", d2_match_count, (exp_n > 3) ? 3 : exp_n);
        chk("first8", d8_first_pos, exp_first);
        chk("first2", d2_first_pos, exp_first);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic start_search(input string txt, input int off, input string pat,
                              input int tl, input int pl, input bit md);
    @(negedge clk); #1;
    for (int i = 0; i < TXT_DEPTH; i++) tmem[i] = 8'h2E;
    for (int i = 0; i < PAT_DEPTH; i++) pmem[i] = 8'h23;
    for (int i = 0; i < txt.len(); i++) tmem[off + i] = txt[i];
    for (int i = 0; i < pat.len(); i++) pmem[i] = pat[i];
    text_len = 7'(tl);
    pat_len = 5'(pl);
    mode = md;
    start = 1'b1;
    last_done = -1;
    exp_s = cyc + 1;
    model(tl, pl, md);
    exp_valid = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task automatic finish_search();
    while (cyc < exp_d + 2) @(negedge clk);
    #1;
  endtask

  task automatic run(input string txt, input int off, input string pat,
                     input int tl, input int pl, input bit md);
    start_search(txt, off, pat, tl, pl, md);
    finish_search();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, d8_busy, 0);
    chk({tag, "_done"}, d8_done, 0);
    chk({tag, "_found"}, d8_found, 0);
    chk({tag, "_count"}, d8_match_count, 0);
    chk({tag, "_first"}, d8_first_pos, 0);
    chk({tag, "_state"}, d8_actual_state, 0);
    chk({tag, "_taddr"}, d8_txt_addr, 0);
    chk({tag, "_paddr"}, d8_pat_addr, 0);
    chk({tag, "_found2"}, d2_found, 0);
    chk({tag, "_count2"}, d2_match_count, 0);
  endtask

  initial begin
    int dur0, dur1, guard;
    repeat (3) @(negedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b1;

    // all overlapping matches
    run("ABABAB", 0, "ABA", 6, 3, MODE_ALL);
    chk("m0_model_dur", exp_d - exp_s, 24);
    chk("m0_model_n", exp_n, 2);
    chk("m0_count", d8_match_count, 2);
    chk("m0_first", d8_first_pos, 0);
    chk("m0_found", d8_found, 1);
    dur0 = last_done - exp_s;
    chk("m0_dut_dur", dur0, 24);

    // stop at first
    run("ABABAB", 0, "ABA", 6, 3, MODE_FIRST);
    chk("m1_model_dur", exp_d - exp_s, 9);
    chk("m1_count", d8_match_count, 1);
    chk("m1_first", d8_first_pos, 0);
    dur1 = last_done - exp_s;
    chk("m1_earlier", (dur1 >= 0 && dur1 < dur0) ? 1 : 0, 1);

    // pattern longer than text, then empty pattern
    run("ABC", 0, "ABCD", 3, 4, MODE_ALL);
    chk("long_pat_dur", last_done - exp_s, 2);
    chk("long_pat_count", d8_match_count, 0);
    chk("long_pat_found", d8_found, 0);
    run("ABABAB", 0, "", 6, 0, MODE_ALL);
    chk("empty_pat_dur", last_done - exp_s, 2);
    chk("empty_pat_found", d8_found, 0);

    // saturation on the 2-bit counter
    run("AAAAAA", 0, "A", 6, 1, MODE_ALL);
    chk("sat_count8", d8_match_count, 6);
    chk("sat_count2", d2_match_count, 3);
    chk("sat_found2", d2_found, 1);
    chk("sat_first2", d2_first_pos, 0);

    // match not at base 0, first-only
    run("XXABAB", 0, "AB", 6, 2, MODE_FIRST);
    chk("off_first", d8_first_pos, 2);
    chk("off_count", d8_match_count, 1);

    // text_len beyond the RAM clamps; only match sits at the last window
    run("QZ", 62, "QZ", 127, 2, MODE_ALL);
    chk("clamp_first", d8_first_pos, 62);
    chk("clamp_count", d8_match_count, 1);

    // reset asserted in CMP after a hit has been recorded
    start_search("ABABAB", 0, "ABA", 6, 3, MODE_ALL);
    guard = 0;
    while (!(d8_found && d8_actual_state == 4'(CMP)) && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    chk("rst_reached_cmp", (guard < 300) ? 1 : 0, 1);
    #1;
    exp_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk_all_zero("midrst");
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b1;
    run("ABABAB", 0, "ABA", 6, 3, MODE_ALL);
    chk("post_rst_count", d8_match_count, 2);
    chk("post_rst_dur", last_done - exp_s, 24);

`ifdef SEARCH_POS_LOG_EN
    run("ABABAB", 0, "AB", 6, 2, MODE_ALL);
    chk("pos_valid", d8_pos_valid, (exp_pos.size() > 0) ? 1 : 0);
    chk("pos_data", d8_pos_data, exp_pos[0]);
    chk("pos_data_lit", d8_pos_data, 0);
    chk("pos_ovf", d8_pos_overflow, (exp_pos.size() > 1) ? 1 : 0);
    chk("pos_ovf_lit", d8_pos_overflow, 1);
    d8_pos_pop = 1'b1;
    @(negedge clk); #1;
    d8_pos_pop = 1'b0;
    chk("pos_after_pop", d8_pos_valid, 0);
    chk("pos_ovf_sticky", d8_pos_overflow, 1);
`endif

    exp_valid = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "[TB] time limit reached");
  end

endmodule
